// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with a FIFO write buffer.
// Loads that miss wait for older buffered stores to drain before refilling from RAM.
module dcache_wt #(
    parameter int INDEX_W    = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_data_i,
    output logic [31:0] mem_data_o,
    input  logic        flush_i,
    output logic        stallreq,
    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    input  logic        ram_ready_i
);
    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = 30 - INDEX_W;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_REFILL} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic [29:0]        r_miss_addr;

    logic [29:0]        r_wb_addr [WBUF_DEPTH];
    logic [3:0]         r_wb_sel  [WBUF_DEPTH];
    logic [31:0]        r_wb_data [WBUF_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic [INDEX_W-1:0] w_index;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_miss_index;
    logic               w_hit, w_lookup, w_load_hit, w_load_miss, w_store;
    logic               w_full, w_empty, w_push, w_drain, w_pop, w_buf_done;
    logic               w_refill, w_refill_done;
    logic               w_unused;

    assign w_unused      = ^mem_addr_i[1:0];
    assign w_index       = mem_addr_i[INDEX_W+1:2];
    assign w_tag         = mem_addr_i[31:INDEX_W+2];
    assign w_miss_index  = r_miss_addr[INDEX_W-1:0];
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);

    // Lookups happen only while idle; every other state is already stalling the pipe.
    assign w_lookup      = rst && (r_state == S_IDLE) && mem_ce_i;
    assign w_load_hit    = w_lookup && !mem_we_i && w_hit;
    assign w_load_miss   = w_lookup && !mem_we_i && !w_hit;
    assign w_store       = w_lookup && mem_we_i;

    assign w_full        = (r_count == CNT_W'(WBUF_DEPTH));
    assign w_empty       = (r_count == '0);
    assign w_push        = w_store && !w_full;
    assign w_drain       = rst && (r_state != S_REFILL) && !w_empty;
    assign w_pop         = w_drain && ram_ready_i;
    assign w_buf_done    = w_empty || (w_pop && (r_count == CNT_W'(1)));
    assign w_refill      = rst && (r_state == S_REFILL);
    assign w_refill_done = w_refill && ram_ready_i;

    always_comb begin
        w_state_next = r_state;
        stallreq     = 1'b0;
        mem_data_o   = '0;
        ram_ce_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_sel_o    = '0;
        ram_data_o   = '0;
        unique case (r_state)
            S_IDLE:   if (w_load_miss) w_state_next = w_buf_done ? S_REFILL : S_DRAIN;
            S_DRAIN:  if (w_buf_done) w_state_next = S_REFILL;
            S_REFILL: if (ram_ready_i) w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (rst)
            stallreq = (r_state != S_IDLE) || w_load_miss || (w_store && w_full);
        if (w_load_hit)
            mem_data_o = r_data[w_index];
        // The refill owns the RAM port; otherwise the buffer head drives it.
        if (w_refill) begin
            ram_ce_o   = 1'b1;
            ram_sel_o  = 4'b1111;
            ram_addr_o = {r_miss_addr, 2'b00};
        end else if (w_drain) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = 1'b1;
            ram_addr_o = {r_wb_addr[r_rd_ptr], 2'b00};
            ram_sel_o  = r_wb_sel[r_rd_ptr];
            ram_data_o = r_wb_data[r_rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_miss_addr <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_miss)
                r_miss_addr <= mem_addr_i[31:2];
            // Flush beats a completing refill so the line stays invalid.
            if (flush_i)
                r_valid <= '0;
            else if (w_refill_done)
                r_valid[w_miss_index] <= 1'b1;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_refill_done) begin
            r_tag[w_miss_index]  <= r_miss_addr[29:INDEX_W];
            r_data[w_miss_index] <= ram_data_i;
        end else if (w_push && w_hit) begin
            for (int b = 0; b < 4; b++)
                if (mem_sel_i[b])
                    r_data[w_index][8*b +: 8] <= mem_data_i[8*b +: 8];
        end
        if (w_push) begin
            r_wb_addr[r_wr_ptr] <= mem_addr_i[31:2];
            r_wb_sel[r_wr_ptr]  <= mem_sel_i;
            r_wb_data[r_wr_ptr] <= mem_data_i;
        end
    end
endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: stimulus queues expected RAM transactions and load data,
// a RAM model/monitor checks them as the DUT presents them.
module tb_dcache_wt;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_ce_i, mem_we_i, flush_i;
    logic [31:0] mem_addr_i, mem_data_i, mem_data_o;
    logic [3:0]  mem_sel_i;
    logic        stallreq, ram_ce_o, ram_we_o, ram_ready_i;
    logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
    logic [3:0]  ram_sel_o;

    always #5 clk = ~clk;

    dcache_wt #(.INDEX_W(4), .WBUF_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
        .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
        .flush_i(flush_i), .stallreq(stallreq),
        .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_sel_o(ram_sel_o), .ram_data_o(ram_data_o),
        .ram_data_i(ram_data_i), .ram_ready_i(ram_ready_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] data;
    } ram_txn_t;

    ram_txn_t    exp_ram[$];
    logic [31:0] exp_load[$];
    logic [31:0] ram_mem[int];
    int checks = 0, errors = 0;
    int ram_lat = 1, ram_cnt = 0, pulse_req = 0, pulse_done = 0;
    bit ram_hold = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(int'(a[31:2]))) return ram_mem[int'(a[31:2])];
        return a ^ 32'h5A5A0000;
    endfunction

    // RAM model and RAM-side monitor: accepts a request after ram_lat cycles of ce.
    always @(negedge clk) begin
        ram_txn_t e;
        logic [31:0] w;
        ram_ready_i = 1'b0;
        ram_data_i  = '0;
        if (!rst || !ram_ce_o) begin
            ram_cnt = 0;
        end else if (!ram_hold || (pulse_req != pulse_done)) begin
            ram_cnt++;
            if ((pulse_req != pulse_done) || ram_cnt >= ram_lat) begin
                pulse_done  = pulse_req;
                ram_cnt     = 0;
                ram_ready_i = 1'b1;
                if (exp_ram.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL ram_unexpected actual=we%0d@%h required=none", ram_we_o, ram_addr_o);
                end else begin
                    e = exp_ram.pop_front();
                    check32("ram_we", 32'(ram_we_o), 32'(e.we));
                    check32("ram_addr", ram_addr_o, e.addr);
                    check32("ram_sel", 32'(ram_sel_o), 32'(e.sel));
                    if (e.we) check32("ram_wdata", ram_data_o, e.data);
                end
                $display("ram %s addr=%h sel=%b data=%h", ram_we_o ? "WR" : "RD",
                         ram_addr_o, ram_sel_o, ram_we_o ? ram_data_o : ram_rd(ram_addr_o));
                if (ram_we_o) begin
                    w = ram_rd(ram_addr_o);
                    for (int b = 0; b < 4; b++)
                        if (ram_sel_o[b]) w[8*b +: 8] = ram_data_o[8*b +: 8];
                    ram_mem[int'(ram_addr_o[31:2])] = w;
                end else begin
                    ram_data_i = ram_rd(ram_addr_o);
                end
            end
        end
    end

    // Pipeline-side monitor: a load completes when it is presented without a stall.
    always @(negedge clk) begin
        if (rst && mem_ce_i && !mem_we_i && !stallreq) begin
            if (exp_load.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL load_unexpected actual=%h required=none", mem_data_o);
            end else begin
                check32("load_data", mem_data_o, exp_load.pop_front());
            end
            $display("load addr=%h data=%h", mem_addr_i, mem_data_o);
        end
    end

    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input int exp_stall,
                           input int n_reads, input int flush_cyc, input bit chk_noram);
        int stalls = 0;
        bit done = 1'b0;
        for (int i = 0; i < n_reads; i++) exp_ram.push_back(ram_txn_t'{1'b0, a, 4'hF, 32'h0});
        exp_load.push_back(d);
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = a; mem_sel_i = '0; mem_data_i = '0;
        for (int c = 0; c < 60 && !done; c++) begin
            flush_i = (c == flush_cyc);
            @(negedge clk);
            if (!stallreq) begin
                done = 1'b1;
                if (chk_noram) check32("hit_no_ram", 32'(ram_ce_o), 32'd0);
            end else begin
                stalls++;
            end
            @(posedge clk); #1;
        end
        flush_i = 1'b0; mem_ce_i = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL load_timeout actual=stalled required=done"); end
        check32("load_stall_cycles", 32'(stalls), 32'(exp_stall));
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d, input int exp_stall);
        int stalls = 0;
        bit done = 1'b0;
        exp_ram.push_back(ram_txn_t'{1'b1, a, s, d});
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = a; mem_sel_i = s; mem_data_i = d;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (!stallreq) done = 1'b1; else stalls++;
            @(posedge clk); #1;
        end
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        if (!done) begin checks++; errors++; $display("FAIL store_timeout actual=stalled required=done"); end
        check32("store_stall_cycles", 32'(stalls), 32'(exp_stall));
        $display("store addr=%h sel=%b data=%h stalls=%0d", a, s, d, stalls);
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int c = 0; c < 200 && !idle; c++) begin
            @(negedge clk);
            if (!ram_ce_o && !stallreq) idle = 1'b1;
        end
        check32("drain_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mem_ce_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0;
        mem_data_i = '0; flush_i = 1'b0; ram_ready_i = 1'b0; ram_data_i = '0;
        ram_mem[int'(32'h100 >> 2)] = 32'hDEADBEEF;
        ram_mem[int'(32'h140 >> 2)] = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_stallreq", 32'(stallreq), 32'd0);
        check32("rst_ram_ce", 32'(ram_ce_o), 32'd0);
        check32("rst_mem_data", mem_data_o, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check32("post_rst_ram_ce", 32'(ram_ce_o), 32'd0);
        @(posedge clk); #1;

        // Cold miss then hit.
        ram_lat = 3;
        do_load(32'h100, 32'hDEADBEEF, 4, 1, -1, 1'b0);
        do_load(32'h100, 32'hDEADBEEF, 0, 0, -1, 1'b1);

        // Byte store hits and writes through.
        do_store(32'h100, 4'b0001, 32'h00000055, 0);
        do_load(32'h100, 32'hDEADBE55, 0, 0, -1, 1'b0);
        wait_idle();

        // Fill the buffer with RAM stalled; the fifth store waits for one pop.
        ram_hold = 1'b1;
        for (int i = 0; i < 4; i++) do_store(32'h300 + 32'(4 * i), 4'hF, 32'hA0A0A0A0 + 32'(i), 0);
        exp_ram.push_back(ram_txn_t'{1'b1, 32'h310, 4'hF, 32'hA0A0A0A4});
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h310; mem_sel_i = 4'hF; mem_data_i = 32'hA0A0A0A4;
        @(negedge clk);
        check32("full_stall", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        pulse_req++;
        @(negedge clk);
        check32("full_pop_stall", 32'(stallreq), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check32("full_push_nostall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        ram_hold = 1'b0; ram_lat = 1;
        wait_idle();

        // Load miss drains older stores first.
        ram_hold = 1'b1;
        do_store(32'h204, 4'hF, 32'h22222222, 0);
        do_store(32'h200, 4'hF, 32'h11111111, 0);
        ram_hold = 1'b0; ram_lat = 2;
        do_load(32'h200, 32'h11111111, 6, 1, -1, 1'b0);

        // Index conflicts on line 0.
        ram_lat = 1;
        do_load(32'h100, 32'hDEADBE55, 2, 1, -1, 1'b0);
        do_load(32'h140, 32'hCAFEF00D, 2, 1, -1, 1'b0);
        do_load(32'h100, 32'hDEADBE55, 2, 1, -1, 1'b0);

        // Flush invalidates; flush during refill completion forces a second refill.
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        do_load(32'h100, 32'hDEADBE55, 2, 1, -1, 1'b0);
        do_load(32'h140, 32'hCAFEF00D, 4, 2, 1, 1'b0);

        // Reset during a refill.
        ram_lat = 5;
        mem_ce_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h180;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        check32("refill_ce", 32'(ram_ce_o), 32'd1);
        check32("refill_addr", ram_addr_o, 32'h180);
        check32("refill_we", 32'(ram_we_o), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check32("async_rst_stall", 32'(stallreq), 32'd0);
        check32("async_rst_ce", 32'(ram_ce_o), 32'd0);
        check32("async_rst_addr", ram_addr_o, 32'd0);
        check32("async_rst_data", mem_data_o, 32'd0);
        mem_ce_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Reset discards a buffered store.
        ram_hold = 1'b1;
        mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h380; mem_sel_i = 4'hF; mem_data_i = 32'h77777777;
        @(negedge clk);
        check32("buf_store_nostall", 32'(stallreq), 32'd0);
        @(posedge clk); #1;
        mem_ce_i = 1'b0; mem_we_i = 1'b0;
        @(negedge clk);
        check32("buf_head_ce", 32'(ram_ce_o), 32'd1);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        ram_hold = 1'b0; ram_lat = 1;
        repeat (4) @(negedge clk);
        check32("buf_cleared", 32'(ram_ce_o), 32'd0);
        @(posedge clk); #1;
        do_load(32'h180, 32'h5A5A0180, 2, 1, -1, 1'b0);

        wait_idle();
        check32("ram_queue_empty", 32'(exp_ram.size()), 32'd0);
        check32("load_queue_empty", 32'(exp_load.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
